// File: rtl/amm_mem_responder_pkg.sv
// amm_mem_responder_pkg
//   Shared types and constants for the Avalon-MM memory responder.
//   - stall_mode_t     : waitrequest back-pressure modes (encoding 3 behaves as STALL_NONE)
//   - LFSR_TAPS        : Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 (maximal length)
//   - MAX_READ_LATENCY : deepest supported read return pipe
//   - lfsr_feedback()  : feedback bit for one LFSR shift
package amm_mem_responder_pkg;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_RAND   = 2'd1,
    STALL_ALWAYS = 2'd2
  } stall_mode_t;

  // Bits 15, 13, 12, 10 of a left-shifting register correspond to x^16, x^14, x^13, x^11.
  localparam logic [15:0] LFSR_TAPS        = 16'hB400;
  localparam int          MAX_READ_LATENCY = 8;

  function automatic logic lfsr_feedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/amm_mem_responder_if.sv
// amm_mem_responder_if
//   Avalon-MM bus bundle for the memory responder: one read port and one write port.
//   Signal names keep the responder-side direction suffixes of the bus definition.
//   Modports:
//     master : drives address/read/write/writedata/byteenable, observes readdata/valid/waitrequest
//     slave  : the responder view (opposite directions)
interface amm_mem_responder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  localparam int BYTE_CNT = DATA_WIDTH / 8;

  // read port
  logic [ADDR_WIDTH-1:0] amm_rd_address_i;
  logic                  amm_rd_read_i;
  logic [DATA_WIDTH-1:0] amm_rd_readdata_o;
  logic                  amm_rd_readdatavalid_o;
  logic                  amm_rd_waitrequest_o;

  // write port
  logic [ADDR_WIDTH-1:0] amm_wr_address_i;
  logic                  amm_wr_write_i;
  logic [DATA_WIDTH-1:0] amm_wr_writedata_i;
  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i;
  logic                  amm_wr_waitrequest_o;

  modport master (
    output amm_rd_address_i, amm_rd_read_i,
    input  amm_rd_readdata_o, amm_rd_readdatavalid_o, amm_rd_waitrequest_o,
    output amm_wr_address_i, amm_wr_write_i, amm_wr_writedata_i, amm_wr_byteenable_i,
    input  amm_wr_waitrequest_o
  );

  modport slave (
    input  amm_rd_address_i, amm_rd_read_i,
    output amm_rd_readdata_o, amm_rd_readdatavalid_o, amm_rd_waitrequest_o,
    input  amm_wr_address_i, amm_wr_write_i, amm_wr_writedata_i, amm_wr_byteenable_i,
    output amm_wr_waitrequest_o
  );

endinterface

// File: rtl/amm_mem_responder_lfsr_stall_gen.sv
// amm_mem_responder_lfsr_stall_gen
//   16-bit Fibonacci LFSR plus stall-mode decode producing registered waitrequest bits
//   for the read and write ports. The LFSR advances every non-reset cycle regardless of mode,
//   so the random pattern does not depend on when random mode was entered.
//   Ports:
//     clk        in   clock
//     srst       in   synchronous reset, active-high (stalls forced high, LFSR reseeded)
//     stall_mode in   2-bit mode: none / random / always / (3 = none)
//     rd_stall   out  registered read-port waitrequest
//     wr_stall   out  registered write-port waitrequest
module amm_mem_responder_lfsr_stall_gen
  import amm_mem_responder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] stall_mode,
  output logic       rd_stall,
  output logic       wr_stall
);

  logic [15:0] lfsr_reg;
  logic        rd_stall_reg;
  logic        wr_stall_reg;
  logic        rd_stall_next;
  logic        wr_stall_next;

  // Stall decision uses the current LFSR state; the new mode is visible after the next edge.
  always_comb begin
    rd_stall_next = 1'b0;
    wr_stall_next = 1'b0;
    case (stall_mode_t'(stall_mode))
      STALL_RAND: begin
        rd_stall_next = lfsr_reg[0];
        wr_stall_next = lfsr_reg[1];
      end
      STALL_ALWAYS: begin
        rd_stall_next = 1'b1;
        wr_stall_next = 1'b1;
      end
      default: begin
        rd_stall_next = 1'b0;
        wr_stall_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      lfsr_reg     <= SEED;
      rd_stall_reg <= 1'b1;
      wr_stall_reg <= 1'b1;
    end else begin
      lfsr_reg     <= {lfsr_reg[14:0], lfsr_feedback(lfsr_reg)};
      rd_stall_reg <= rd_stall_next;
      wr_stall_reg <= wr_stall_next;
    end
  end

  assign rd_stall = rd_stall_reg;
  assign wr_stall = wr_stall_reg;

endmodule

// File: rtl/amm_mem_responder.sv
// amm_mem_responder
//   Avalon-MM memory slave with one pipelined read port and one byte-enabled write port
//   sharing a single word array. Reads return after a fixed latency in issue order;
//   a read and write to the same word in the same cycle returns the old data.
//   Ports:
//     clk_i        in   clock
//     srst_i       in   synchronous reset, active-high (memory contents are kept)
//     stall_mode_i in   waitrequest mode: 0 none, 1 LFSR random, 2 always, 3 none
//     bus          slave modport of amm_mem_responder_if (read + write ports)
//     rd_cnt_o     out  accepted reads, wraps mod 2**32
//     wr_cnt_o     out  accepted writes, wraps mod 2**32
module amm_mem_responder
  import amm_mem_responder_pkg::*;
#(
  parameter int          DATA_WIDTH   = 64,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          BYTE_CNT     = DATA_WIDTH / 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [1:0]          stall_mode_i,
  amm_mem_responder_if.slave  bus,
  output logic [31:0]         rd_cnt_o,
  output logic [31:0]         wr_cnt_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Out-of-range latencies are pulled into the supported 1..MAX_READ_LATENCY window.
  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  logic rd_stall;
  logic wr_stall;
  logic rd_accept;
  logic wr_accept;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LAT-1:0]        pipe_valid_reg;
  logic [DATA_WIDTH-1:0] pipe_data_reg [LAT];
  logic [31:0]           rd_cnt_reg;
  logic [31:0]           wr_cnt_reg;

  amm_mem_responder_lfsr_stall_gen #(
    .SEED (LFSR_SEED)
  ) u_lfsr_stall_gen (
    .clk        (clk_i),
    .srst       (srst_i),
    .stall_mode (stall_mode_i),
    .rd_stall   (rd_stall),
    .wr_stall   (wr_stall)
  );

  assign bus.amm_rd_waitrequest_o = rd_stall;
  assign bus.amm_wr_waitrequest_o = wr_stall;

  // Reset wins over a handshake presented in the same cycle.
  assign rd_accept = bus.amm_rd_read_i  && !rd_stall && !srst_i;
  assign wr_accept = bus.amm_wr_write_i && !wr_stall && !srst_i;

  // Byte-lane write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < BYTE_CNT; b++) begin
        if (bus.amm_wr_byteenable_i[b]) begin
          mem[bus.amm_wr_address_i][b*8 +: 8] <= bus.amm_wr_writedata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read return pipe. Stage 0 is the RAM output register; because it samples the array
  // with a non-blocking read at the same edge as the write, a colliding write is not seen.
  // Data stages only load alongside a valid, so the last stage holds its value when idle.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pipe_valid_reg <= '0;
      for (int k = 0; k < LAT; k++) begin
        pipe_data_reg[k] <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data_reg[0] <= mem[bus.amm_rd_address_i];
      end
      for (int k = 1; k < LAT; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        if (pipe_valid_reg[k-1]) begin
          pipe_data_reg[k] <= pipe_data_reg[k-1];
        end
      end
    end
  end

  assign bus.amm_rd_readdatavalid_o = pipe_valid_reg[LAT-1];
  assign bus.amm_rd_readdata_o      = pipe_data_reg[LAT-1];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      if (rd_accept) rd_cnt_reg <= rd_cnt_reg + 32'd1;
      if (wr_accept) wr_cnt_reg <= wr_cnt_reg + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_reg;
  assign wr_cnt_o = wr_cnt_reg;

endmodule
